// File: rtl/trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : trace_monitor
// Purpose  : Commit-trace capture buffer (PC / ALU / cycle stamp) with halt
//            detection and stop-full, ring and halt-triggered capture modes.
// Revision : 1.0 - initial release
// ============================================================================
module trace_monitor #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CW          = 32,
    parameter int HALT_CYCLES = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    input  logic                       valid_in,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [XLEN-1:0]            alu_in,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [XLEN-1:0]            rd_pc,
    output logic [XLEN-1:0]            rd_alu,
    output logic [CW-1:0]              rd_cycle,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       halted,
    output logic [CW-1:0]              cycle
);

    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CNTW = c_AW + 1;
    localparam int c_SW   = $clog2(HALT_CYCLES + 1);

    localparam logic [1:0] c_MODE_OFF       = 2'd0;
    localparam logic [1:0] c_MODE_STOP_FULL = 2'd1;
    localparam logic [1:0] c_MODE_HALT_TRIG = 2'd3;

    localparam logic [c_CNTW-1:0] c_DEPTH_CNT = c_CNTW'(DEPTH);
    localparam logic [c_SW-1:0]   c_HALT_MAX  = c_SW'(HALT_CYCLES);

    logic [XLEN-1:0]   r_mem_pc  [DEPTH];
    logic [XLEN-1:0]   r_mem_alu [DEPTH];
    logic [CW-1:0]     r_mem_cyc [DEPTH];

    logic [c_AW-1:0]   r_head;
    logic [c_AW-1:0]   r_tail;
    logic [c_CNTW-1:0] r_count;
    logic              r_overflow;
    logic              r_halted;
    logic [CW-1:0]     r_cycle;
    logic [c_SW-1:0]   r_streak;
    logic [XLEN-1:0]   r_last_pc;
    logic              r_have_last;

    logic              w_full;
    logic              w_empty;
    logic              w_frozen;
    logic              w_push_req;
    logic              w_pop;
    logic              w_write;
    logic              w_drop;
    logic              w_overwrite;
    logic              w_advance;
    logic              w_same_pc;
    logic [c_SW-1:0]   w_streak_next;

    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_empty    = (r_count == '0);
    assign w_frozen   = (mode == c_MODE_HALT_TRIG) && r_halted;
    assign w_push_req = valid_in && (mode != c_MODE_OFF) && !w_frozen;
    assign w_pop      = !w_empty && rd_ready;

    // When full the tail equals the head, so a ring-mode write lands on the
    // oldest slot and the head must advance whether or not a pop occurs.
    assign w_write     = w_push_req && (!w_full || (mode != c_MODE_STOP_FULL));
    assign w_drop      = w_push_req && w_full && (mode == c_MODE_STOP_FULL);
    assign w_overwrite = w_push_req && w_full && (mode != c_MODE_STOP_FULL) && !w_pop;
    assign w_advance   = w_pop || w_overwrite;

    assign w_same_pc     = r_have_last && (pc_in == r_last_pc);
    assign w_streak_next = !w_same_pc                ? c_SW'(1)   :
                           (r_streak == c_HALT_MAX)  ? c_HALT_MAX :
                                                       r_streak + c_SW'(1);

    always_ff @(posedge clock) begin
        if (!clear && w_write) begin
            r_mem_pc[r_tail]  <= pc_in;
            r_mem_alu[r_tail] <= alu_in;
            r_mem_cyc[r_tail] <= r_cycle;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_halted    <= 1'b0;
            r_streak    <= '0;
            r_last_pc   <= '0;
            r_have_last <= 1'b0;
        end else if (clear) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_halted    <= 1'b0;
            r_streak    <= '0;
            r_have_last <= 1'b0;
        end else begin
            if (w_write) begin
                r_tail <= r_tail + c_AW'(1);
            end
            if (w_advance) begin
                r_head <= r_head + c_AW'(1);
            end
            unique case ({w_write, w_advance})
                2'b10:   r_count <= r_count + c_CNTW'(1);
                2'b01:   r_count <= r_count - c_CNTW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop || w_overwrite) begin
                r_overflow <= 1'b1;
            end
            // Halt detection watches every valid sample, independent of mode.
            if (valid_in) begin
                r_streak    <= w_streak_next;
                r_last_pc   <= pc_in;
                r_have_last <= 1'b1;
                if (w_streak_next == c_HALT_MAX) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign rd_valid = !w_empty;
    assign rd_pc    = rd_valid ? r_mem_pc[r_head]  : '0;
    assign rd_alu   = rd_valid ? r_mem_alu[r_head] : '0;
    assign rd_cycle = rd_valid ? r_mem_cyc[r_head] : '0;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign halted   = r_halted;
    assign cycle    = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_monitor
// Purpose  : Directed and randomized checks of trace_monitor against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 32;
    localparam int HALT  = 8;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   clear;
    logic [1:0]             mode;
    logic                   valid_in;
    logic [XLEN-1:0]        pc_in;
    logic [XLEN-1:0]        alu_in;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [XLEN-1:0]        rd_pc;
    logic [XLEN-1:0]        rd_alu;
    logic [CW-1:0]          rd_cycle;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   halted;
    logic [CW-1:0]          cycle;

    always #5 clock = ~clock;

    trace_monitor #(
        .XLEN        (XLEN),
        .DEPTH       (DEPTH),
        .CW          (CW),
        .HALT_CYCLES (HALT)
    ) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear),
        .mode     (mode),
        .valid_in (valid_in),
        .pc_in    (pc_in),
        .alu_in   (alu_in),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_pc    (rd_pc),
        .rd_alu   (rd_alu),
        .rd_cycle (rd_cycle),
        .count    (count),
        .overflow (overflow),
        .halted   (halted),
        .cycle    (cycle)
    );

    typedef struct {
        logic [CW-1:0]   cyc;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
    } entry_t;

    entry_t          m_q[$];
    logic            m_ovf;
    logic            m_halted;
    int              m_streak;
    logic [XLEN-1:0] m_last;
    logic            m_have;
    logic [CW-1:0]   m_cycle;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_halted = 1'b0;
        m_streak = 0;
        m_last   = '0;
        m_have   = 1'b0;
        m_cycle  = '0;
    endtask

    task automatic model_update(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                                input logic rdy, input logic clr, input logic [1:0] md);
        entry_t e;
        logic   push;
        logic   pop;
        logic   full;
        e.cyc = m_cycle;
        e.pc  = pc;
        e.alu = alu;
        if (clr) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_halted = 1'b0;
            m_streak = 0;
            m_have   = 1'b0;
        end else begin
            push = v && (md != 2'd0) && !((md == 2'd3) && m_halted);
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (!full) begin
                    m_q.push_back(e);
                end else if (md == 2'd1) begin
                    m_ovf = 1'b1;
                end else begin
                    if (!pop) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_q.push_back(e);
                end
            end
            if (v) begin
                if (m_have && pc == m_last) m_streak = (m_streak < HALT) ? m_streak + 1 : HALT;
                else                        m_streak = 1;
                m_last = pc;
                m_have = 1'b1;
                if (m_streak == HALT) m_halted = 1'b1;
            end
        end
        m_cycle = m_cycle + 1;
    endtask

    task automatic compare_all();
        check("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
        check("count", 64'(count), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("halted", 64'(halted), 64'(m_halted));
        check("cycle", 64'(cycle), 64'(m_cycle));
        if (m_q.size() != 0) begin
            check("rd_pc", 64'(rd_pc), 64'(m_q[0].pc));
            check("rd_alu", 64'(rd_alu), 64'(m_q[0].alu));
            check("rd_cycle", 64'(rd_cycle), 64'(m_q[0].cyc));
        end
    endtask

    // One clock: compare, drive, clock, update the model.
    task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic rdy,
                        input logic clr, input logic [1:0] md);
        logic [XLEN-1:0] alu;
        compare_all();
        alu      = $urandom;
        valid_in = v;
        pc_in    = pc;
        alu_in   = alu;
        rd_ready = rdy;
        clear    = clr;
        mode     = md;
        @(posedge clock);
        #1;
        model_update(v, pc, alu, rdy, clr, md);
    endtask

    task automatic do_clear();
        step(1'b0, '0, 1'b0, 1'b1, 2'd0);
    endtask

    initial begin
        logic [CW-1:0]   prev_cyc;
        logic [XLEN-1:0] rpc;
        logic [1:0]      rmode;

        reset_n  = 1'b0;
        clear    = 1'b0;
        mode     = 2'd0;
        valid_in = 1'b0;
        pc_in    = '0;
        alu_in   = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_pc", 64'(rd_pc), 64'd0);
        check("reset_rd_alu", 64'(rd_alu), 64'd0);
        check("reset_rd_cycle", 64'(rd_cycle), 64'd0);
        check("reset_cycle", 64'(cycle), 64'd0);
        reset_n = 1'b1;
        model_reset();

        // Three samples, then drain in order with rising stamps.
        for (int i = 0; i < 3; i++) step(1'b1, XLEN'(4 * i), 1'b0, 1'b0, 2'd1);
        check("basic_count", 64'(count), 64'd3);
        prev_cyc = '0;
        for (int i = 0; i < 3; i++) begin
            check("basic_pc", 64'(rd_pc), 64'(4 * i));
            if (i > 0) check("basic_cyc_inc", 64'(rd_cycle > prev_cyc), 64'd1);
            prev_cyc = rd_cycle;
            step(1'b0, '0, 1'b1, 1'b0, 2'd1);
        end
        check("basic_empty", 64'(rd_valid), 64'd0);

        // Stop-when-full keeps the first DEPTH samples.
        do_clear();
        for (int i = 0; i < 20; i++) step(1'b1, XLEN'(32'h100 + 4 * i), 1'b0, 1'b0, 2'd1);
        check("stop_count", 64'(count), 64'(DEPTH));
        check("stop_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("stop_drain_pc", 64'(rd_pc), 64'(32'h100 + 4 * i));
            step(1'b0, '0, 1'b1, 1'b0, 2'd1);
        end

        // Ring keeps the newest DEPTH samples.
        do_clear();
        for (int i = 0; i < 20; i++) step(1'b1, XLEN'(4 * i), 1'b0, 1'b0, 2'd2);
        check("ring_count", 64'(count), 64'(DEPTH));
        check("ring_ovf", 64'(overflow), 64'd1);
        check("ring_head", 64'(rd_pc), 64'h10);
        for (int i = 0; i < DEPTH; i++) begin
            check("ring_drain_pc", 64'(rd_pc), 64'(4 * (i + 4)));
            step(1'b0, '0, 1'b1, 1'b0, 2'd2);
        end

        // Ring full with simultaneous push and pop.
        do_clear();
        for (int i = 0; i < DEPTH; i++) step(1'b1, XLEN'(4 * i), 1'b0, 1'b0, 2'd2);
        check("pp_head_before", 64'(rd_pc), 64'h0);
        step(1'b1, XLEN'(32'h999), 1'b1, 1'b0, 2'd2);
        check("pp_count", 64'(count), 64'(DEPTH));
        check("pp_ovf", 64'(overflow), 64'd0);
        check("pp_head_after", 64'(rd_pc), 64'h4);

        // Halt-triggered capture.
        do_clear();
        step(1'b1, XLEN'(32'h0), 1'b0, 1'b0, 2'd3);
        step(1'b1, XLEN'(32'h4), 1'b0, 1'b0, 2'd3);
        for (int i = 0; i < HALT; i++) begin
            check("halt_not_yet", 64'(halted), 64'd0);
            step(1'b1, XLEN'(32'h8), 1'b0, 1'b0, 2'd3);
        end
        check("halt_set", 64'(halted), 64'd1);
        step(1'b1, XLEN'(32'hC), 1'b0, 1'b0, 2'd3);
        check("halt_count", 64'(count), 64'd10);

        // Asynchronous reset with five stored entries.
        do_clear();
        for (int i = 0; i < 5; i++) step(1'b1, XLEN'(4 * i), 1'b0, 1'b0, 2'd2);
        check("pre_reset_count", 64'(count), 64'd5);
        reset_n = 1'b0;
        #2;
        check("async_count", 64'(count), 64'd0);
        check("async_rd_valid", 64'(rd_valid), 64'd0);
        check("async_cycle", 64'(cycle), 64'd0);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Clear with five entries and a detected halt; cycle keeps running.
        for (int i = 0; i < HALT; i++) step(1'b1, XLEN'(32'h40), 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) step(1'b1, XLEN'(32'h80 + 4 * i), 1'b0, 1'b0, 2'd1);
        check("pre_clear_count", 64'(count), 64'd5);
        check("pre_clear_halted", 64'(halted), 64'd1);
        prev_cyc = cycle;
        do_clear();
        check("clear_count", 64'(count), 64'd0);
        check("clear_halted", 64'(halted), 64'd0);
        check("clear_cycle_runs", 64'(cycle), 64'(prev_cyc + 1));

        // Randomized traffic against the model.
        rpc   = '0;
        rmode = 2'd2;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) rmode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rpc = XLEN'(4 * $urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0), rpc, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0), rmode);
        end
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
